img_out_packer: RTL and testbench

- Consumer at the output end of the lane-detection pipeline.
- Drains the 8-bit processed-pixel output FIFO and packs 4 consecutive pixels into one 32-bit word.
- Writes each word to a word-addressed output frame buffer (e.g. the DDR3 bridge / on-chip framebuffer) using a write handshake with backpressure.
- Tracks frame boundaries: pulses frame_done once every WIDTH*HEIGHT pixels and counts completed frames.

---
 rtl/img_out_packer_if.sv | 39 +++
 rtl/img_out_packer.sv | 128 ++++++++++++
 tb/tb_img_out_packer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_out_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : img_out_packer_if
// Brief    : Pixel FIFO read port and frame-buffer write port of img_out_packer.
// Revision : 1.0 - initial release
// ============================================================================
interface img_out_packer_if #(
    parameter int ADDR_BITS = 16
);
    logic                 in_rd_en;
    logic                 in_empty;
    logic [7:0]           in_dout;
    logic                 mem_wr_en;
    logic [ADDR_BITS-1:0] mem_wr_addr;
    logic [31:0]          mem_wr_data;
    logic                 mem_wait;

    // master: the packer; slave: the FIFO and the frame-buffer sink
    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_wait
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_wait
    );
endinterface
`default_nettype wire

// File: rtl/img_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : img_out_packer
// Brief    : Packs 4 FIFO pixels little-endian into 32-bit words, writes them to
//            a word-addressed frame buffer and tracks frame boundaries.
//            Define IMG_OUT_CHECKSUM_EN to add the per-frame frame_checksum port.
// Revision : 1.0 - initial release
// ============================================================================
module img_out_packer #(
    parameter int WIDTH           = 512,
    parameter int HEIGHT          = 288,
    parameter int WORDS_PER_FRAME = WIDTH * HEIGHT / 4,
    parameter int ADDR_BITS       = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
    input  wire              clock,
    input  wire              reset,
    img_out_packer_if.master bus,
    output logic             frame_done,
    output logic [15:0]      frame_count
`ifdef IMG_OUT_CHECKSUM_EN
    ,
    output logic [31:0]      frame_checksum
`endif
);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    localparam logic [ADDR_BITS-1:0] c_last_addr = ADDR_BITS'(WORDS_PER_FRAME - 1);

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [1:0]           r_idx;
    logic [7:0]           r_lane0;
    logic [7:0]           r_lane1;
    logic [7:0]           r_lane2;
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_data;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_frame_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_accept    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_FILL: begin
                w_pop = !bus.in_empty;
                if (w_pop && (r_idx == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_accept    = !bus.mem_wait;
                w_frame_end = w_accept && (r_addr == c_last_addr);
                if (w_accept) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    assign bus.in_rd_en    = w_pop;
    assign bus.mem_wr_en   = (r_state == S_WRITE);
    assign bus.mem_wr_addr = r_addr;
    assign bus.mem_wr_data = r_data;

    // The 4th pixel goes straight into the output word; lanes 0..2 wait for it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx       <= 2'd0;
            r_lane0     <= 8'd0;
            r_lane1     <= 8'd0;
            r_lane2     <= 8'd0;
            r_addr      <= '0;
            r_data      <= 32'd0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_done <= w_frame_end;
            if (w_pop) begin
                case (r_idx)
                    2'd0:    r_lane0 <= bus.in_dout;
                    2'd1:    r_lane1 <= bus.in_dout;
                    2'd2:    r_lane2 <= bus.in_dout;
                    default: r_data  <= {bus.in_dout, r_lane2, r_lane1, r_lane0};
                endcase
                r_idx <= r_idx + 2'd1;
            end
            if (w_frame_end) begin
                r_addr      <= '0;
                frame_count <= frame_count + 16'd1;
            end else if (w_accept) begin
                r_addr <= r_addr + ADDR_BITS'(1);
            end
        end
    end

`ifdef IMG_OUT_CHECKSUM_EN
    logic [31:0] r_csum_acc;

    // Pops never coincide with an accept, so the final word is already summed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_csum_acc     <= 32'd0;
            frame_checksum <= 32'd0;
        end else if (w_frame_end) begin
            frame_checksum <= r_csum_acc;
            r_csum_acc     <= 32'd0;
        end else if (w_pop) begin
            r_csum_acc <= r_csum_acc + {24'd0, bus.in_dout};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_out_packer
// Brief    : Scoreboard bench for img_out_packer at WIDTH=8, HEIGHT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_out_packer;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 2;
    localparam int WPF    = WIDTH * HEIGHT / 4;
    localparam int AB     = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_done;
    logic [15:0] frame_count;
`ifdef IMG_OUT_CHECKSUM_EN
    logic [31:0] frame_checksum;
`endif

    img_out_packer_if #(.ADDR_BITS(AB)) bus ();

    img_out_packer #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_count(frame_count)
`ifdef IMG_OUT_CHECKSUM_EN
        ,
        .frame_checksum(frame_checksum)
`endif
    );

    always #5 clock = ~clock;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [7:0]      fifo_q[$];
    logic [AB+31:0]  sb_q[$];
    logic [31:0]     cs_q[$];
    int              m_idx = 0;
    logic [31:0]     m_word = 32'd0;
    logic [31:0]     m_sum = 32'd0;
    logic [AB-1:0]   m_addr = '0;
    bit              rand_mode = 1'b0;
    int              stall_addr = -1;
    int              stall_left = 0;
    bit              exp_done = 1'b0;
    int              writes = 0;
    int              writes_since_reset = 0;
    int              done_pulses = 0;
    int              stall_cycles = 0;
    logic [31:0]     last_data = 32'd0;
    logic [31:0]     first_data = 32'd0;
    logic [AB-1:0]   first_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference packer: builds the expected word/address stream as pixels enter the FIFO.
    task automatic push_pixel(input logic [7:0] p);
        fifo_q.push_back(p);
        m_word[8*m_idx +: 8] = p;
        m_sum = m_sum + 32'(p);
        if (m_idx == 3) begin
            sb_q.push_back({m_addr, m_word});
            if (m_addr == AB'(WPF - 1)) begin
                m_addr = '0;
                cs_q.push_back(m_sum);
                m_sum = 32'd0;
            end else begin
                m_addr = m_addr + AB'(1);
            end
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    task automatic step();
        logic [AB+31:0] e;
        @(negedge clock);
        if (reset) begin
            bus.in_empty = 1'b1;
            bus.mem_wait = 1'b0;
        end else begin
            bus.in_empty = (fifo_q.size() == 0) || (rand_mode && ($urandom_range(0, 4) == 0));
            if (rand_mode) begin
                bus.mem_wait = ($urandom_range(0, 3) == 0);
            end else if (bus.mem_wr_en && (int'(bus.mem_wr_addr) == stall_addr) && (stall_left > 0)) begin
                bus.mem_wait = 1'b1;
                stall_left--;
            end else begin
                bus.mem_wait = 1'b0;
            end
        end
        bus.in_dout = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
        #1;
        if (reset) begin
            exp_done = 1'b0;
            return;
        end
        check_eq("frame_done", 32'(frame_done), 32'(exp_done));
        if (frame_done) begin
            done_pulses++;
`ifdef IMG_OUT_CHECKSUM_EN
            check_eq("checksum_pending", 32'(cs_q.size() != 0), 32'd1);
            if (cs_q.size() != 0) check_eq("frame_checksum", frame_checksum, cs_q.pop_front());
`endif
        end
        exp_done = 1'b0;
        if (bus.in_empty) check_eq("rd_while_empty", 32'(bus.in_rd_en), 32'd0);
        if (bus.in_rd_en && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
        if (bus.mem_wr_en) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_write", 32'(bus.mem_wr_en), 32'd0);
            end else begin
                e = sb_q[0];
                check_eq("wr_addr", 32'(bus.mem_wr_addr), 32'(e[AB+31:32]));
                check_eq("wr_data", bus.mem_wr_data, e[31:0]);
                if (bus.mem_wait) begin
                    check_eq("rd_in_stall", 32'(bus.in_rd_en), 32'd0);
                    stall_cycles++;
                end else begin
                    void'(sb_q.pop_front());
                    if (writes_since_reset == 0) begin
                        first_data = bus.mem_wr_data;
                        first_addr = bus.mem_wr_addr;
                    end
                    writes++;
                    writes_since_reset++;
                    last_data = bus.mem_wr_data;
                    exp_done  = (e[AB+31:32] == AB'(WPF - 1));
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        bit ok;
        n = 0;
        while (((fifo_q.size() != 0) || (sb_q.size() != 0)) && (n < budget)) begin
            step();
            n++;
        end
        ok = (fifo_q.size() == 0) && (sb_q.size() == 0);
        check_eq("drain_timeout", 32'(ok), 32'd1);
        step();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        fifo_q.delete();
        sb_q.delete();
        cs_q.delete();
        m_idx = 0;
        m_word = 32'd0;
        m_sum = 32'd0;
        m_addr = '0;
        exp_done = 1'b0;
        writes_since_reset = 0;
        done_pulses = 0;
        stall_left = 0;
        stall_addr = -1;
    endtask

    initial begin
        int w0;
        bus.in_empty = 1'b1;
        bus.in_dout  = 8'd0;
        bus.mem_wait = 1'b0;

        // Reset values
        step();
        step();
        check_eq("rst_rd_en", 32'(bus.in_rd_en), 32'd0);
        check_eq("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check_eq("rst_addr", 32'(bus.mem_wr_addr), 32'd0);
        check_eq("rst_data", bus.mem_wr_data, 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_count", 32'(frame_count), 32'd0);
`ifdef IMG_OUT_CHECKSUM_EN
        check_eq("rst_checksum", frame_checksum, 32'd0);
`endif
        do_reset();

        // One frame 0x00..0x0F, no stalls
        for (int i = 0; i < 16; i++) push_pixel(8'(i));
        drain(500);
        check_eq("t1_writes", 32'(writes_since_reset), 32'd4);
        check_eq("t1_last_data", last_data, 32'h0F0E0D0C);
        check_eq("t1_done_pulses", 32'(done_pulses), 32'd1);
        check_eq("t1_count", 32'(frame_count), 32'd1);
        check_eq("t1_addr_wrap", 32'(bus.mem_wr_addr), 32'd0);
`ifdef IMG_OUT_CHECKSUM_EN
        check_eq("t1_checksum", frame_checksum, 32'h00000078);
`endif

        // Same frame with a 3-cycle stall on word 1
        stall_addr   = 1;
        stall_left   = 3;
        stall_cycles = 0;
        for (int i = 0; i < 16; i++) push_pixel(8'(i));
        drain(500);
        check_eq("t2_stall_cycles", 32'(stall_cycles), 32'd3);
        check_eq("t2_count", 32'(frame_count), 32'd2);
        check_eq("t2_last_data", last_data, 32'h0F0E0D0C);
        stall_addr = -1;

        // FIFO runs dry mid-word
        w0 = writes;
        push_pixel(8'hAA);
        push_pixel(8'hBB);
        repeat (12) step();
        check_eq("t3_no_write_gap", 32'(writes), 32'(w0));
        check_eq("t3_wr_en_gap", 32'(bus.mem_wr_en), 32'd0);
        push_pixel(8'hCC);
        push_pixel(8'hDD);
        drain(500);
        check_eq("t3_word", last_data, 32'hDDCCBBAA);
        check_eq("t3_writes", 32'(writes), 32'(w0 + 1));

        // Reset mid-frame, then a full frame
        do_reset();
        for (int i = 0; i < 6; i++) push_pixel(8'(8'h50 + i));
        drain(500);
        check_eq("t4_pre_writes", 32'(writes_since_reset), 32'd1);
        do_reset();
        check_eq("t4_addr_after_rst", 32'(bus.mem_wr_addr), 32'd0);
        check_eq("t4_wr_en_after_rst", 32'(bus.mem_wr_en), 32'd0);
        for (int i = 0; i < 16; i++) push_pixel(8'(8'h10 + i));
        drain(500);
        check_eq("t4_first_data", first_data, 32'h13121110);
        check_eq("t4_first_addr", 32'(first_addr), 32'd0);
        check_eq("t4_count", 32'(frame_count), 32'd1);
`ifdef IMG_OUT_CHECKSUM_EN
        check_eq("t4_checksum", frame_checksum, 32'h00000178);
`endif

        // Three back-to-back frames of 0xFF
        do_reset();
        for (int i = 0; i < 48; i++) push_pixel(8'hFF);
        drain(1000);
        check_eq("t5_done_pulses", 32'(done_pulses), 32'd3);
        check_eq("t5_count", 32'(frame_count), 32'd3);
`ifdef IMG_OUT_CHECKSUM_EN
        check_eq("t5_checksum", frame_checksum, 32'h00000FF0);
`endif

        // Random empty/wait over 1000 frames
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 1000 * WIDTH * HEIGHT; i++) push_pixel(8'($urandom_range(0, 255)));
        drain(60000);
        rand_mode = 1'b0;
        check_eq("t6_count", 32'(frame_count), 32'd1000);
        check_eq("t6_done_pulses", 32'(done_pulses), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
